// File: rtl/s247_wb_master_if.sv
// Wishbone master-side bus bundle for s247_wb_master.
interface s247_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/s247_wb_master.sv
// Single-outstanding Wishbone master fed by a command FIFO, with per-request
// ack timeout and a saturating timeout counter.
module s247_wb_master #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [31:0]             cmd_adr,
  input  logic [31:0]             cmd_dat,
  input  logic [3:0]              cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_dat,
  output logic                    rsp_we,
  output logic                    rsp_err,
  s247_wb_master_if.master        wb,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic          ack_take, timeout;
  cmd_t          head;

  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   adr_q, dat_q;
  logic [7:0]    to_cnt_q;
  logic [31:0]   rsp_dat_q;
  logic          rsp_we_q, rsp_err_q;
  logic [7:0]    err_count_q;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_q[rd_ptr_q];

  assign wb.wbm_cyc_o = (state_q == ST_REQ);
  assign wb.wbm_stb_o = (state_q == ST_REQ);
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = sel_q;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign err_count = err_count_q;

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ack is checked before the timeout so it wins a tie.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    ack_take = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wb.wbm_ack_i) begin
          ack_take = 1'b1;
          state_d  = ST_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command FIFO storage; pointer reset makes stale entries unreachable.
  always_ff @(posedge wb_clk_i) begin
    if (push && !wb_rst_i) fifo_q[wr_ptr_q] <= '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Bus request registers, timeout counter and response capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      to_cnt_q    <= '0;
      rsp_dat_q   <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (pop) begin
        we_q     <= head.we;
        sel_q    <= head.sel;
        adr_q    <= head.adr;
        dat_q    <= head.dat;
        to_cnt_q <= '0;
      end else if (state_q == ST_REQ) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
      if (ack_take) begin
        rsp_dat_q <= we_q ? '0 : wb.wbm_dat_i;
        rsp_we_q  <= we_q;
        rsp_err_q <= 1'b0;
      end else if (timeout) begin
        rsp_dat_q <= '0;
        rsp_we_q  <= we_q;
        rsp_err_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_s247_wb_master.sv
// Directed self-checking bench for s247_wb_master (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_s247_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [31:0] rsp_dat;
  logic        busy;
  logic [7:0]  err_count;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Responder: 0 = registered single-cycle ack, 1 = never ack,
  // 2 = ack during the 16th stb cycle, 3 = ack held high.
  int          resp_mode   = 0;
  logic [31:0] resp_data   = '0;
  logic        use_adr_dat = 1'b0;
  logic        ack         = 1'b0;
  logic        stb_prev    = 1'b0;
  int          scnt        = 0;

  s247_wb_master_if wb ();

  s247_wb_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err),
    .wb        (wb),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  assign wb.wbm_dat_i = use_adr_dat ? (32'hCAFE0000 | wb.wbm_adr_o) : resp_data;
  assign wb.wbm_ack_i = ack;

  initial begin
    forever begin
      @(negedge clk);
      stb_prev = wb.wbm_stb_o;
      @(posedge clk);
      #2;
      if (stb_prev) scnt++;
      else          scnt = 0;
      case (resp_mode)
        0:       ack = stb_prev && !ack;
        2:       ack = stb_prev && (scnt == 15);
        3:       ack = 1'b1;
        default: ack = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    check("cmd_ready_on_push", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic count_cyc(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb.wbm_cyc_o) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          ncyc;
    logic [31:0] adrs [5];
    logic        seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0;

    // Reset, with a push offered during reset that must be dropped.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h44; cmd_dat = 32'h55; cmd_sel = 4'hF;
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
    check("rst_we", 32'(wb.wbm_we_o), 32'd0);
    check("rst_sel", 32'(wb.wbm_sel_o), 32'd0);
    check("rst_adr", wb.wbm_adr_o, 32'd0);
    check("rst_dat", wb.wbm_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_we", 32'(rsp_we), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick(); tick();
    check("rst_push_dropped_busy", 32'(busy), 32'd0);
    check("rst_push_dropped_cyc", 32'(wb.wbm_cyc_o), 32'd0);

    // Ack while idle is ignored.
    resp_mode = 3;
    tick(); tick(); tick();
    check("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_ack_busy", 32'(busy), 32'd0);
    resp_mode = 0;
    tick(); tick();

    // Write with single-cycle responder.
    push(1'b1, 32'h0000000C, 32'h00123456, 4'hF);
    check("wr_e0_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    check("wr_e0_busy", 32'(busy), 32'd1);
    tick();
    check("wr_e1_cyc", 32'(wb.wbm_cyc_o), 32'd1);
    check("wr_e1_stb", 32'(wb.wbm_stb_o), 32'd1);
    check("wr_e1_adr", wb.wbm_adr_o, 32'h0000000C);
    check("wr_e1_dat", wb.wbm_dat_o, 32'h00123456);
    check("wr_e1_sel", 32'(wb.wbm_sel_o), 32'hF);
    check("wr_e1_we", 32'(wb.wbm_we_o), 32'd1);
    tick();
    check("wr_e2_cyc", 32'(wb.wbm_cyc_o), 32'd1);
    check("wr_e2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("wr_e3_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    check("wr_e3_stb", 32'(wb.wbm_stb_o), 32'd0);
    check("wr_e3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_e3_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_e3_rsp_we", 32'(rsp_we), 32'd1);
    check("wr_e3_rsp_dat", rsp_dat, 32'd0);
    check("wr_adr_retained", wb.wbm_adr_o, 32'h0000000C);
    check("wr_dat_retained", wb.wbm_dat_o, 32'h00123456);
    take_rsp();
    check("wr_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_done_busy", 32'(busy), 32'd0);

    // Read; response must hold while rsp_ready is low.
    resp_data = 32'h000000FF;
    push(1'b0, 32'h00000008, 32'hAAAA5555, 4'hF);
    tick(); tick(); tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_dat", rsp_dat, 32'h000000FF);
    check("rd_rsp_we", 32'(rsp_we), 32'd0);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    resp_data = 32'h0;
    tick();
    check("rd_hold_valid", 32'(rsp_valid), 32'd1);
    check("rd_hold_dat", rsp_dat, 32'h000000FF);
    take_rsp();

    // Timeout: no ack, 16 REQ cycles, error response.
    resp_mode = 1;
    resp_data = 32'hDEADBEEF;
    push(1'b0, 32'h00000010, 32'h0, 4'hF);
    count_cyc(ncyc);
    check("to_cyc_cycles", 32'(ncyc), 32'd16);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_dat", rsp_dat, 32'd0);
    check("to_err_count", 32'(err_count), 32'd1);
    take_rsp();

    // Ack on the 16th REQ cycle wins over the timeout.
    resp_mode = 2;
    resp_data = 32'h12345678;
    push(1'b0, 32'h00000014, 32'h0, 4'hF);
    count_cyc(ncyc);
    check("tie_cyc_cycles", 32'(ncyc), 32'd16);
    check("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tie_rsp_err", 32'(rsp_err), 32'd0);
    check("tie_rsp_dat", rsp_dat, 32'h12345678);
    check("tie_err_count", 32'(err_count), 32'd1);
    take_rsp();
    resp_mode = 0;
    tick(); tick();

    // Backpressure: 1 in flight + 4 queued, in-order responses.
    use_adr_dat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      adrs[k] = 32'h00000100 + 32'(k * 4);
      push(1'b0, adrs[k], 32'h0, 4'h3);
    end
    check("bp_full_ready", 32'(cmd_ready), 32'd0);
    tick(); tick(); tick();
    check("bp_still_full", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_rsp("bp_rsp_wait");
      check("bp_rsp_dat", rsp_dat, 32'hCAFE0000 | adrs[k]);
      take_rsp();
      if (k == 0) begin
        check("bp_ready_after_take", 32'(cmd_ready), 32'd0);
        tick();
        check("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
      end
    end
    tick();
    check("bp_done_busy", 32'(busy), 32'd0);
    use_adr_dat = 1'b0;

    // Reset on the 2nd REQ cycle with 2 commands queued.
    resp_mode = 1;
    push(1'b1, 32'h00000200, 32'h1, 4'hF);
    push(1'b1, 32'h00000204, 32'h2, 4'hF);
    push(1'b1, 32'h00000208, 32'h3, 4'hF);
    check("rm_in_req", 32'(wb.wbm_cyc_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    check("rm_stb", 32'(wb.wbm_stb_o), 32'd0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rm_err_count", 32'(err_count), 32'd0);
    resp_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb.wbm_cyc_o || rsp_valid || busy) seen = 1'b1;
    end
    check("rm_queue_discarded", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s247_wb_master.md
S247_WB_MASTER -- requirements
Module: s247_wb_master

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, command FIFO entries, power of 2, at least 2; TIMEOUT_CYCLES, default 255, maximum cycles a request waits for ack, 2..255.
REQ-002 wb_clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-004 Command input ports SHALL be:
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
REQ-005 Response output ports SHALL be:
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_we  out  1  echo of the command's cmd_we
- rsp_err  out  1  transaction timed out
REQ-006 Wishbone master ports SHALL be: wbm_cyc_o out 1, wbm_stb_o out 1, wbm_we_o out 1, wbm_sel_o out 4, wbm_adr_o out 32, wbm_dat_o out 32, wbm_dat_i in 32, wbm_ack_i in 1.
REQ-007 Status output ports SHALL be: busy out 1, high when state is not IDLE or the FIFO is not empty; err_count out 8, saturating timeout count.

Function
REQ-008 Command FIFO: push when cmd_valid && cmd_ready; cmd_ready = !full; pointers wrap modulo FIFO_DEPTH; entry order preserved.
REQ-009 FSM states SHALL be IDLE, REQ and RESP, with one transaction outstanding at most.
REQ-010 IDLE with FIFO non-empty: pop the head entry at the edge, latch it into the wbm_adr/dat/sel/we registers, clear the timeout counter, go to REQ.
REQ-011 IDLE with FIFO empty: remain in IDLE.
REQ-012 A push and a pop in the same edge SHALL both take effect, and the count SHALL be unchanged.
REQ-013 In REQ, wbm_cyc_o and wbm_stb_o SHALL be high; address, data, sel and we SHALL be stable for the whole REQ.
REQ-014 REQ with wbm_ack_i sampled high: capture rsp_dat = wbm_dat_i for reads or 0 for writes, set rsp_err=0, go to RESP; cyc/stb SHALL be low from the next cycle.
REQ-015 REQ timeout: when the counter reaches TIMEOUT_CYCLES-1 with ack low, go to RESP with rsp_err=1 and rsp_dat=0, and increment err_count, saturating at 255.
REQ-016 Ack and the timeout condition in the same cycle: ack SHALL win; no error and no err_count increment.
REQ-017 wbm_ack_i outside REQ SHALL be ignored.
REQ-018 RESP: rsp_valid high; rsp_dat, rsp_we and rsp_err held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-019 No pop SHALL occur while in REQ or RESP; the FIFO may fill while rsp_ready is low.
REQ-020 Latency: command accepted at edge E, FIFO empty, FSM in IDLE: cyc/stb SHALL be high from edge E+1.
REQ-021 Latency with a 1-cycle registered responder: ack is seen at edge E+2 and rsp_valid SHALL be high from edge E+3.
REQ-022 Per-transaction throughput SHALL be at least 4 cycles: IDLE, REQ of at least 1 cycle, RESP, then IDLE.
REQ-023 When cyc/stb are low, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL retain their last values.

Reset
REQ-024 wb_rst_i high at an edge SHALL give: state IDLE, FIFO empty, cmd_ready=1, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_we=0, rsp_err=0, busy=0, err_count=0.
REQ-025 Reset in REQ or RESP SHALL abort the transaction: cyc/stb low from the next cycle, no response, queued commands discarded.
REQ-026 A push presented during a reset cycle SHALL be dropped.

Verification
REQ-027 Write: cmd adr=0x0C, dat=0x00123456, we=1, sel=0xF, with a 1-cycle-ack responder -> cyc/stb high for exactly 2 cycles; wbm_adr_o=0x0C; rsp_valid at E+3 with rsp_err=0, rsp_we=1, rsp_dat=0.
REQ-028 Read: adr=0x08, responder returns 0x000000FF -> rsp_dat=0x000000FF, rsp_we=0, rsp_err=0.
REQ-029 Timeout: TIMEOUT_CYCLES=16, responder never acks -> cyc high for exactly 16 cycles, then rsp_err=1, rsp_dat=0, err_count=1.
REQ-030 Ack tie: TIMEOUT_CYCLES=16, ack on the 16th REQ cycle -> rsp_err=0 and err_count unchanged.
REQ-031 Backpressure: rsp_ready=0, push 5 commands with FIFO_DEPTH=4 -> 1 command in flight plus 4 queued, and cmd_ready=0 until the first response is taken; responses then arrive in push order.
REQ-032 Reset mid-transaction: wb_rst_i pulsed on the 2nd REQ cycle with 2 commands queued -> cyc=0 next cycle, no rsp_valid, busy=0, cmd_ready=1.
